// File: rtl/ysyx_23060208_pc_gen_if.sv
// Fetch-PC offer channel between the PC generator (master) and the IFU (slave).
interface ysyx_23060208_pc_gen_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned EPOCH_WIDTH = 2
);
  logic                   valid;
  logic                   ready;
  logic [DATA_WIDTH-1:0]  pc;
  logic [EPOCH_WIDTH-1:0] epoch;

  modport master (output valid, output pc, output epoch, input ready);
  modport slave  (input valid, input pc, input epoch, output ready);
endinterface

// File: rtl/ysyx_23060208_pc_gen.sv
// NPC front-end PC generator: BOOT/RUN/HALT, trap/branch redirect with epoch tagging.
// Optional YSYX_PC_MISALIGN_CHK_EN rejects misaligned redirect targets instead of masking them.
module ysyx_23060208_pc_gen #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(32'h2000_0000),
  parameter int unsigned           INST_BYTES   = 4,
  parameter int unsigned           EPOCH_WIDTH  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  trap_valid,
  input  logic [DATA_WIDTH-1:0] trap_pc,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  halt_req,
  ysyx_23060208_pc_gen_if.master ifu,
  output logic                  halted,
  output logic                  misalign_err
);

  localparam logic [DATA_WIDTH-1:0] PC_INC     = DATA_WIDTH'(INST_BYTES);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = DATA_WIDTH'(INST_BYTES - 1);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t state;

  logic                  fire_c;
  logic                  redir_bad_c;
  logic                  redir_ok_c;
  logic [DATA_WIDTH-1:0] trap_tgt_c;
  logic [DATA_WIDTH-1:0] redir_tgt_c;

  // valid is a register, so fire only ever happens in RUN
  assign fire_c = ifu.valid & ifu.ready;

`ifdef YSYX_PC_MISALIGN_CHK_EN
  assign trap_tgt_c  = trap_pc;
  assign redir_tgt_c = redirect_pc;
  assign redir_bad_c = redirect_valid & (|(redirect_pc & ALIGN_MASK));
`else
  assign trap_tgt_c  = trap_pc & ~ALIGN_MASK;
  assign redir_tgt_c = redirect_pc & ~ALIGN_MASK;
  assign redir_bad_c = 1'b0;
`endif

  assign redir_ok_c = redirect_valid & ~redir_bad_c;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_BOOT;
      ifu.valid    <= 1'b0;
      ifu.pc       <= RESET_VECTOR;
      ifu.epoch    <= '0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      if (trap_valid) begin
        state     <= S_RUN;
        ifu.valid <= 1'b1;
        ifu.pc    <= trap_tgt_c;
        ifu.epoch <= ifu.epoch + EPOCH_WIDTH'(1);
        halted    <= 1'b0;
      end else if (redir_ok_c) begin
        state     <= S_RUN;
        ifu.valid <= 1'b1;
        ifu.pc    <= redir_tgt_c;
        ifu.epoch <= ifu.epoch + EPOCH_WIDTH'(1);
        halted    <= 1'b0;
      end else begin
        // a rejected redirect falls through to the lower-priority action
        misalign_err <= redir_bad_c;
        case (state)
          S_BOOT: begin
            state     <= S_RUN;
            ifu.valid <= 1'b1;
            halted    <= 1'b0;
          end
          S_RUN: begin
            if (fire_c) begin
              ifu.pc <= ifu.pc + PC_INC;
            end
            if (halt_req) begin
              state     <= S_HALT;
              ifu.valid <= 1'b0;
              halted    <= 1'b1;
            end
          end
          S_HALT: begin
            ifu.valid <= 1'b0;
            halted    <= 1'b1;
          end
          default: begin
            state     <= S_BOOT;
            ifu.valid <= 1'b0;
            halted    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
